// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between icache fills and dcache fills/write-backs.
// Optional performance counters are enabled by defining CACHE_ARBITER_PERF_EN.
module cache_arbiter #(
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_pmem_read,
  input  logic [15:0]       icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [15:0]       dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef CACHE_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_igrants,
  output logic [31:0]       perf_dgrants,
  output logic [31:0]       perf_conflicts
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [15:0]       pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic i_req;
  logic d_req;
  logic conflict;
  logic grant_i;
  logic grant_d;

  assign i_req    = icache_pmem_read;
  assign d_req    = dcache_pmem_read | dcache_pmem_write;
  assign conflict = (state_q == IDLE) & i_req & d_req;

  // dcache wins conflicts unless icache has already lost MAX_WAIT of them in a row.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        if (wait_cnt_q >= MAX_WAIT_C) grant_i = 1'b1;
        else                          grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
        if (grant_i) begin
          state_d        = SERVE_I;
          pmem_read_d    = 1'b1;
          pmem_address_d = icache_pmem_address;
        end else if (grant_d) begin
          state_d        = SERVE_D;
          pmem_address_d = dcache_pmem_address;
          // A simultaneous read+write from dcache is resolved as a write-back.
          if (dcache_pmem_write) begin
            pmem_write_d = 1'b1;
            pmem_wdata_d = dcache_pmem_wdata;
          end else begin
            pmem_read_d  = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_i) begin
      wait_cnt_d = 4'd0;
    end else if (grant_d && i_req && (wait_cnt_q != 4'hF)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wait_cnt_q     <= 4'd0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 16'd0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Responses pass straight through so the cache sees resp in the same cycle as pmem.
  assign icache_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign dcache_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

`ifdef CACHE_ARBITER_PERF_EN
  logic [31:0] perf_igrants_q, perf_igrants_d;
  logic [31:0] perf_dgrants_q, perf_dgrants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;

  always_comb begin
    perf_igrants_d   = perf_igrants_q   + {31'd0, grant_i};
    perf_dgrants_d   = perf_dgrants_q   + {31'd0, grant_d};
    perf_conflicts_d = perf_conflicts_q + {31'd0, conflict};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_igrants_q   <= 32'd0;
      perf_dgrants_q   <= 32'd0;
      perf_conflicts_q <= 32'd0;
    end else begin
      perf_igrants_q   <= perf_igrants_d;
      perf_dgrants_q   <= perf_dgrants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_igrants   = perf_igrants_q;
  assign perf_dgrants   = perf_dgrants_q;
  assign perf_conflicts = perf_conflicts_q;
`else
  logic unused_conflict;
  assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a pmem responder model plus a queue of expected grants.
// Performance-counter checks are included when CACHE_ARBITER_PERF_EN is defined.
module tb_cache_arbiter;
  localparam int LINE_W   = 128;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              icache_pmem_read;
  logic [15:0]       icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [15:0]       dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
`ifdef CACHE_ARBITER_PERF_EN
  logic [31:0]       perf_igrants;
  logic [31:0]       perf_dgrants;
  logic [31:0]       perf_conflicts;
`endif

  cache_arbiter #(.LINE_W(LINE_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
`ifdef CACHE_ARBITER_PERF_EN
    ,
    .perf_igrants        (perf_igrants),
    .perf_dgrants        (perf_dgrants),
    .perf_conflicts      (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              is_wr;
    logic [15:0]       addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic is_wr, input logic [15:0] addr,
                      input logic [LINE_W-1:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Waits for the next grant, checks it against the head of the queue, holds for lat cycles,
  // then returns pmem_resp with rd and checks the response routing.
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit drop_i_g,
                       input bit drop_d_g, input bit drop_on_resp, output int waited);
    exp_t e;
    bit   found;
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      waited++;
      if (pmem_read || pmem_write) found = 1'b1;
    end
    if (!found) begin
      check("grant_timeout", 1'b0, 1'b1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_grant", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    check("grant_addr", pmem_address, e.addr);
    check("grant_write", pmem_write, e.is_wr);
    check("grant_read", pmem_read, !e.is_wr);
    if (e.is_wr) check("grant_wdata", pmem_wdata, e.wdata);
    if (drop_i_g) icache_pmem_read = 1'b0;
    if (drop_d_g) begin
      dcache_pmem_read  = 1'b0;
      dcache_pmem_write = 1'b0;
    end
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      check("hold_addr", pmem_address, e.addr);
      check("hold_strobe", {pmem_write, pmem_read}, {e.is_wr, !e.is_wr});
      if (e.is_wr) check("hold_wdata", pmem_wdata, e.wdata);
      check("hold_no_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    check("resp_i", icache_pmem_resp, !e.is_d);
    check("resp_d", dcache_pmem_resp, e.is_d);
    check("resp_rdata", e.is_d ? dcache_pmem_rdata : icache_pmem_rdata, rd);
    check("resp_strobe", {pmem_write, pmem_read}, {e.is_wr, !e.is_wr});
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = {4{$urandom}};
    if (drop_on_resp) begin
      if (e.is_d) begin
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        icache_pmem_read = 1'b0;
      end
    end
    check("strobe_drop", {pmem_write, pmem_read}, 2'b00);
  endtask

  int waited;
  logic [LINE_W-1:0] wb_data;
`ifdef CACHE_ARBITER_PERF_EN
  logic [31:0] pi0, pd0, pc0;
`endif

  initial begin
    reset_n             = 1'b0;
    icache_pmem_read    = 1'b0;
    icache_pmem_address = 16'h0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = 16'h0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
    wb_data             = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_strobes", {pmem_write, pmem_read}, 2'b00);
    check("rst_addr", pmem_address, 16'h0);
    check("rst_wdata", pmem_wdata, '0);
    check("rst_resps", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
    reset_n = 1'b1;
    @(negedge clk);

    // Icache-only line fill
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    push(1'b0, 1'b0, 16'h1230, '0);
    serve(3, {16{8'hA5}}, 1'b0, 1'b0, 1'b1, waited);
    check("i_only_latency", waited, 1);

    // Dcache write-back
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h4440;
    dcache_pmem_wdata   = wb_data;
    push(1'b1, 1'b1, 16'h4440, wb_data);
    serve(4, '0, 1'b0, 1'b0, 1'b1, waited);
    check("d_wb_latency", waited, 1);

    // Simultaneous requests with no prior losses: dcache first, icache right after
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1240;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h4450;
    push(1'b1, 1'b0, 16'h4450, '0);
    push(1'b0, 1'b0, 16'h1240, '0);
    serve(2, {4{32'hDEAD_BEEF}}, 1'b0, 1'b0, 1'b1, waited);
    check("both_d_latency", waited, 1);
    serve(2, {4{32'hCAFE_F00D}}, 1'b0, 1'b0, 1'b1, waited);
    check("both_i_after_d", waited, 1);
    @(negedge clk);

    // Starvation bound: dcache keeps requesting, icache wins after MAX_WAIT losses
`ifdef CACHE_ARBITER_PERF_EN
    pi0 = perf_igrants;
    pd0 = perf_dgrants;
    pc0 = perf_conflicts;
`endif
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h2000;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h3000;
    for (int n = 0; n < MAX_WAIT; n++) push(1'b1, 1'b0, 16'h3000, '0);
    push(1'b0, 1'b0, 16'h2000, '0);
    for (int n = 0; n < MAX_WAIT; n++) begin
      serve(1, {4{$urandom}}, 1'b0, 1'b0, 1'b0, waited);
      check("starve_d_spacing", waited, 1);
    end
    serve(2, {8{16'h5A5A}}, 1'b0, 1'b1, 1'b1, waited);
    check("starve_i_grant", waited, 1);
    check("starve_drained", sb.size(), 0);
`ifdef CACHE_ARBITER_PERF_EN
    check("perf_dgrants", perf_dgrants - pd0, 32'd4);
    check("perf_igrants", perf_igrants - pi0, 32'd1);
    check("perf_conflicts", perf_conflicts - pc0, 32'd5);
`endif
    @(negedge clk);

    // Loss count cleared by the icache grant: next conflict goes to dcache again
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h2010;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h3010;
    push(1'b1, 1'b0, 16'h3010, '0);
    push(1'b0, 1'b0, 16'h2010, '0);
    serve(1, {4{32'h1111_2222}}, 1'b0, 1'b0, 1'b1, waited);
    serve(1, {4{32'h3333_4444}}, 1'b0, 1'b0, 1'b1, waited);
    @(negedge clk);

    // Dcache read and write together resolve to a write-back
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h4460;
    dcache_pmem_wdata   = ~wb_data;
    push(1'b1, 1'b1, 16'h4460, ~wb_data);
    serve(2, '0, 1'b0, 1'b0, 1'b1, waited);

    // Requester drops mid-service: transaction still completes
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h6660;
    push(1'b0, 1'b0, 16'h6660, '0);
    serve(3, {4{32'h7777_8888}}, 1'b1, 1'b0, 1'b1, waited);

    // pmem_resp while idle is ignored
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    check("idle_resp_i", icache_pmem_resp, 1'b0);
    check("idle_resp_d", dcache_pmem_resp, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b0;
    check("idle_resp_strobes", {pmem_write, pmem_read}, 2'b00);

    // Asynchronous reset in the middle of a write-back
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h5550;
    dcache_pmem_wdata   = wb_data;
    @(negedge clk);
    check("pre_rst_write", pmem_write, 1'b1);
    #2;
    reset_n   = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("async_rst_write", pmem_write, 1'b0);
    check("async_rst_addr", pmem_address, 16'h0);
    check("async_rst_wdata", pmem_wdata, '0);
    check("async_rst_resp", dcache_pmem_resp, 1'b0);
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {pmem_write, pmem_read}, 2'b00);
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h7770;
    push(1'b0, 1'b0, 16'h7770, '0);
    serve(2, {4{32'h0BAD_F00D}}, 1'b0, 1'b0, 1'b1, waited);
    check("post_rst_latency", waited, 1);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
